// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit Galois LFSR: width, seed, next-state function, checker states.
// Pure declarations and combinational helpers; no latency, no flow control.
// Used by the generator, the sequence checker and their benches.
package lfsr_pkg;

   localparam int                LFSR_W    = 6;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 6'h3F;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   // Galois step: bit 5 shifts out and is fed back into bits 0, 1 and 4.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[4], q[5] ^ q[3], q[2], q[1], q[5] ^ q[0], q[5]};
   endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Sample stream and status bundle between an LFSR source (master) and the sequence checker (slave).
// No storage; latency and backpressure are those of the attached modules.
// No backpressure signal: the source never stalls on the checker.
interface lfsr_seq_checker_if import lfsr_pkg::*; #(
   parameter int ERR_W = 16
);

   logic              clr;
   logic              in_valid;
   logic [LFSR_W-1:0] in_data;
   logic              locked;
   logic              err_pulse;
   logic [ERR_W-1:0]  err_cnt;
   logic              zero_seen;

   modport master (
      output clr, in_valid, in_data,
      input  locked, err_pulse, err_cnt, zero_seen
   );

   modport slave (
      input  clr, in_valid, in_data,
      output locked, err_pulse, err_cnt, zero_seen
   );

endinterface

// File: rtl/lfsr_next_comb.sv
// Combinational LFSR next-word predictor, reusable by generator and checker.
// Latency: zero cycles, purely combinational.
// Backpressure: not applicable.
module lfsr_next_comb import lfsr_pkg::*; (
   input  logic [LFSR_W-1:0] q,
   output logic [LFSR_W-1:0] n
);

   assign n = lfsr_next(q);

endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR stream checker: locks after SYNC_LEN predicted matches, counts locked-state errors, flags all-zero words.
// Latency: all outputs registered, updated on the edge that samples the word.
// Backpressure: none; every valid word is consumed, in_valid=0 holds all state.
module lfsr_seq_checker import lfsr_pkg::*; #(
   parameter int SYNC_LEN = 4,
   parameter int LOSS_LEN = 3,
   parameter int ERR_W    = 16
) (
   input  logic                clk,
   input  logic                rst_b,
   lfsr_seq_checker_if.slave   bus
);

   localparam int               CNT_MAX   = (SYNC_LEN > LOSS_LEN) ? SYNC_LEN : LOSS_LEN;
   localparam int               CNT_W     = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_LEN - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   chk_state_t        state;
   logic [LFSR_W-1:0] prev;
   logic [LFSR_W-1:0] pred;
   logic              prev_ok;
   logic [CNT_W-1:0]  match_cnt;
   logic [CNT_W-1:0]  miss_cnt;
   logic              locked_q;
   logic              err_pulse_q;
   logic [ERR_W-1:0]  err_cnt_q;
   logic              zero_seen_q;
   logic              match;

   lfsr_next_comb u_next (
      .q (prev),
      .n (pred)
   );

   // All-zero is the LFSR lock-up state, so it never counts as a match.
   assign match = prev_ok && (bus.in_data == pred) && (bus.in_data != '0);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= HUNT;
         prev        <= '0;
         prev_ok     <= 1'b0;
         match_cnt   <= '0;
         miss_cnt    <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         zero_seen_q <= 1'b0;
      end else if (bus.clr) begin
         state       <= HUNT;
         prev        <= '0;
         prev_ok     <= 1'b0;
         match_cnt   <= '0;
         miss_cnt    <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         zero_seen_q <= 1'b0;
      end else begin
         err_pulse_q <= 1'b0;
         if (bus.in_valid) begin
            if (bus.in_data == '0) begin
               zero_seen_q <= 1'b1;
            end
            case (state)
               HUNT: begin
                  prev    <= bus.in_data;
                  prev_ok <= 1'b1;
                  if (match) begin
                     if (match_cnt == SYNC_LAST) begin
                        state     <= LOCKED;
                        locked_q  <= 1'b1;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        match_cnt <= match_cnt + CNT_W'(1);
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  // Flywheel: advance on the prediction so a single bad word costs one error.
                  if (match) begin
                     prev     <= pred;
                     miss_cnt <= '0;
                  end else begin
                     err_pulse_q <= 1'b1;
                     if (err_cnt_q != ERR_MAX) begin
                        err_cnt_q <= err_cnt_q + ERR_W'(1);
                     end
                     if (miss_cnt == LOSS_LAST) begin
                        state     <= HUNT;
                        locked_q  <= 1'b0;
                        prev      <= bus.in_data;
                        prev_ok   <= 1'b1;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        prev     <= pred;
                        miss_cnt <= miss_cnt + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state    <= HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.zero_seen = zero_seen_q;

endmodule
